// File: rtl/dc_pwm.sv
// dc_pwm -- duty-cycle PWM generator, 8 slots per period.
//
// Takes a 3-bit duty code in eighths from the duty-control store stage and
// drives a registered, glitch-free PWM output. A new code is taken only at the
// period wrap. Rising duty is slew-limited to one step per period (soft-start).
// Falling duty is applied in a single step. The slot counter is exported as
// `phase` so that the store stage only updates while `phase == 0`.
//
// Parameters
//   PRESCALE      clk cycles per PWM slot (1..255)
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (overrides en)
//   en            enable; low holds every register at zero
//   dc_control    requested duty, 0..7 eighths
//   pwm_out       registered PWM output (never 100% high)
//   phase         current slot index, 0..7
//   duty_applied  duty currently in effect
//   period_start  one-clk pulse in the cycle phase first reads 0 after a wrap

module dc_pwm #(
    parameter int PRESCALE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] dc_control,
    output logic       pwm_out,
    output logic [2:0] phase,
    output logic [2:0] duty_applied,
    output logic       period_start
);

    // A one-cycle prescale still needs a 1-bit counter so the compare below stays legal.
    localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic             wrap;
    logic [2:0]       duty_next;

    assign tick = en && (pre_cnt == PRE_LAST);
    assign wrap = tick && (phase == 3'd7);

    // Rising requests climb one code per period. Falling requests take effect at once.
    // The increment cannot overflow, because it only happens while dc_control > duty_applied.
    always_comb begin
        duty_next = duty_applied;
        if (wrap) begin
            if (dc_control > duty_applied) begin
                duty_next = duty_applied + 3'd1;
            end else if (dc_control < duty_applied) begin
                duty_next = dc_control;
            end
        end
    end

    // Idle (rst or !en) clears everything. Re-enabling therefore restarts at
    // slot 0 with a fresh ramp from duty 0. pwm_out is driven from the current
    // phase/duty registers, so it lags them by one clk.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            pre_cnt      <= '0;
            phase        <= 3'd0;
            duty_applied <= 3'd0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            pre_cnt      <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) begin
                phase <= phase + 3'd1;
            end
            duty_applied <= duty_next;
            pwm_out      <= (phase < duty_applied);
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_dc_pwm.sv
// tb_dc_pwm -- scoreboard bench for dc_pwm.
//
// Two instances share one clock:
//   dut_a  PRESCALE=2  ramp, decrease, zero duty, enable drop, mid-run reset
//   dut_b  PRESCALE=1  period_start/phase alignment, en falling on the wrap edge
//
// The stimulus pushes one hand-computed record per expected period_start.
// Each record holds the new duty, the pwm high count over the period just
// ended, and the period length. A monitor per instance pops a record on every
// period_start and compares it. The monitors also check that every idle cycle
// shows zeros, and that duty never moves except at a wrap.

module tb_dc_pwm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1;
    logic       en_a  = 1'b0;
    logic [2:0] dc_a  = 3'd0;
    logic       pwm_a;
    logic [2:0] phase_a;
    logic [2:0] duty_a;
    logic       ps_a;

    logic       rst_b = 1'b1;
    logic       en_b  = 1'b0;
    logic [2:0] dc_b  = 3'd3;
    logic       pwm_b;
    logic [2:0] phase_b;
    logic [2:0] duty_b;
    logic       ps_b;

    dc_pwm #(.PRESCALE(2)) dut_a (
        .clk          (clk),
        .rst          (rst_a),
        .en           (en_a),
        .dc_control   (dc_a),
        .pwm_out      (pwm_a),
        .phase        (phase_a),
        .duty_applied (duty_a),
        .period_start (ps_a)
    );

    dc_pwm #(.PRESCALE(1)) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .en           (en_b),
        .dc_control   (dc_b),
        .pwm_out      (pwm_b),
        .phase        (phase_b),
        .duty_applied (duty_b),
        .period_start (ps_b)
    );

    typedef struct {
        int duty;
        int hc;
        int interval;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    int vectors     = 0;
    int miscompares = 0;

    int hc_a        = 0;
    int cyc_a       = 0;
    int prev_duty_a = 0;
    int cyc_b       = 0;

    // Registered idle flag: tells the monitors that the edge just taken was a reset/idle edge.
    logic idle_qa = 1'b1;
    logic idle_qb = 1'b1;
    always @(posedge clk) begin
        idle_qa <= rst_a || !en_a;
        idle_qb <= rst_b || !en_b;
    end

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push_a(input int d, input int hc);
        exp_t e;
        e.duty     = d;
        e.hc       = hc;
        e.interval = 16;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int d);
        exp_t e;
        e.duty     = d;
        e.hc       = 0;
        e.interval = 8;
        q_b.push_back(e);
    endtask

    // Waits until the chosen scoreboard is empty. The wait is bounded.
    task automatic drain(input bit sel);
        int n;
        int left;
        n    = 0;
        left = sel ? q_b.size() : q_a.size();
        while (left != 0 && n < 600) begin
            @(negedge clk);
            #1;
            n++;
            left = sel ? q_b.size() : q_a.size();
        end
        check(sel ? "drain_b_leftover" : "drain_a_leftover", left, 0);
        if (sel) q_b.delete();
        else     q_a.delete();
    endtask

    // mode 0: phase_a == val, mode 1: pwm_a == val, mode 2: phase_b == val
    task automatic wait_for(input string name, input int mode, input int val);
        int n;
        int hit;
        n   = 0;
        hit = 0;
        while (hit == 0 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
            case (mode)
                0:       hit = (int'(phase_a) == val) ? 1 : 0;
                1:       hit = (int'(pwm_a) == val) ? 1 : 0;
                default: hit = (int'(phase_b) == val) ? 1 : 0;
            endcase
        end
        check(name, hit, 1);
    endtask

    // Monitor A
    always @(negedge clk) begin
        if (idle_qa) begin
            check("idle_a_pwm", int'(pwm_a), 0);
            check("idle_a_phase", int'(phase_a), 0);
            check("idle_a_duty", int'(duty_a), 0);
            check("idle_a_period_start", int'(ps_a), 0);
            hc_a        = 0;
            cyc_a       = 0;
            prev_duty_a = 0;
        end else begin
            cyc_a++;
            hc_a += int'(pwm_a);
            if (ps_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_period_start", 1, 0);
                end else begin
                    ea = q_a.pop_front();
                    check("a_duty_at_wrap", int'(duty_a), ea.duty);
                    check("a_pwm_high_count", hc_a, ea.hc);
                    check("a_period_len", cyc_a, ea.interval);
                    check("a_phase_at_start", int'(phase_a), 0);
                end
                hc_a  = 0;
                cyc_a = 0;
            end else begin
                check("a_duty_hold", int'(duty_a), prev_duty_a);
            end
            prev_duty_a = int'(duty_a);
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (idle_qb) begin
            check("idle_b_period_start", int'(ps_b), 0);
            check("idle_b_phase", int'(phase_b), 0);
            check("idle_b_duty", int'(duty_b), 0);
            check("idle_b_pwm", int'(pwm_b), 0);
            cyc_b = 0;
        end else begin
            cyc_b++;
            if (ps_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_period_start", 1, 0);
                end else begin
                    eb = q_b.pop_front();
                    check("b_duty_at_wrap", int'(duty_b), eb.duty);
                    check("b_period_len", cyc_b, eb.interval);
                    check("b_phase_at_start", int'(phase_b), 0);
                end
                cyc_b = 0;
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;

        // Soft-start ramp to 7. Each record's pwm count is 2*(previous duty).
        rst_a = 1'b0;
        en_a  = 1'b1;
        dc_a  = 3'd7;
        push_a(1, 0);  push_a(2, 2);  push_a(3, 4);  push_a(4, 6);
        push_a(5, 8);  push_a(6, 10); push_a(7, 12); push_a(7, 14);
        push_a(7, 14);
        drain(0);

        // Mid-period request for a lower duty. It takes effect in one step at the next wrap.
        wait_for("wait_a_phase4", 0, 4);
        dc_a = 3'd2;
        push_a(2, 14); push_a(2, 4); push_a(2, 4);
        drain(0);

        // Zero duty for 5 periods.
        dc_a = 3'd0;
        push_a(0, 4);
        for (int i = 0; i < 5; i++) push_a(0, 0);
        drain(0);

        // Ramp to 5, then drop en at phase 3.
        dc_a = 3'd5;
        push_a(1, 0); push_a(2, 2); push_a(3, 4); push_a(4, 6); push_a(5, 8);
        drain(0);
        wait_for("wait_a_phase3", 0, 3);
        check("a_duty_before_drop", int'(duty_a), 5);
        en_a = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        en_a = 1'b1;
        push_a(1, 0); push_a(2, 2); push_a(3, 4);
        drain(0);

        // One-clk reset while pwm is high.
        wait_for("wait_a_pwm_high", 1, 1);
        rst_a = 1'b1;
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        push_a(1, 0); push_a(2, 2);
        drain(0);
        en_a = 1'b0;

        // PRESCALE=1: every period is 8 clk long. en falls on the wrap edge.
        rst_b = 1'b0;
        en_b  = 1'b1;
        push_b(1); push_b(2); push_b(3); push_b(3);
        drain(1);
        wait_for("wait_b_phase7", 2, 7);
        en_b = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        en_b = 1'b1;
        push_b(1); push_b(2);
        drain(1);
        en_b = 1'b0;

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dc_pwm.md
# dc_pwm

Duty-cycle PWM generator that sits directly downstream of the duty-control store stage. It consumes the 3-bit `dc_control` duty code and produces a glitch-free PWM output with 8 slots per period. New codes are latched only at period boundaries, with rising duty slew-limited to one step per period. It also exports its slot counter as `phase`, which the design feeds back as the store stage's `trigger`, so the store updates only at `phase == 0`.

## Interface
- `PRESCALE`, default 4: clk cycles per PWM slot. Legal range is 1..255.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  reset, synchronous, active-high.
- `en`  input  1  enable; low forces the idle state.
- `dc_control`  input  3  requested duty in eighths (0..7), from the store stage.
- `pwm_out`  output  1  registered PWM output.
- `phase`  output  3  current slot index (0..7), routed to the store stage `trigger`.
- `duty_applied`  output  3  duty currently in effect.
- `period_start`  output  1  one-clk pulse when `phase` wraps 7→0.

## Operation
- Internal prescaler `pre_cnt` is `ceil(log2(PRESCALE))` bits wide, minimum 1 bit.
  - `tick` = `en && pre_cnt == PRESCALE-1`.
  - On `tick`, `pre_cnt` returns to 0; otherwise it increments.
  - With `PRESCALE=1`, `tick = en` on every cycle.
- `phase` increments on `tick` and wraps 7→0. It holds when there is no tick.
- Duty update at the wrap edge (`tick && phase == 7`). Sample `dc_control` as `target`, then:
  - `target > duty_applied`: `duty_applied + 1` (soft-start; at most 1 step per period).
  - `target < duty_applied`: `target` (immediate decrease, for safety).
  - equal: hold.
- `duty_applied` never changes at any edge other than the wrap edge.
- `pwm_out` <= `en && (phase < duty_applied)`, using the current register values.
  - Duty 0 gives a constant low output.
  - Duty 7 gives 7 of 8 slots high.
  - Output is never 100% high.
- `period_start` <= `tick && phase == 7`. It asserts in the same cycle that `phase` first reads 0 after a wrap.
- `en` low, evaluated at each edge:
  - `pre_cnt`, `phase`, `duty_applied`, `pwm_out` and `period_start` all go to 0.
  - Re-enabling restarts at slot 0 with a fresh soft-start ramp from duty 0.
- `rst` high: all registers go to 0 at the next edge. `rst` overrides `en`.
- Comparison rule: `phase < duty_applied` is an unsigned 3-bit compare. No arithmetic widening.
- `duty_applied` increment cannot overflow because `target` is at most 7.

## Timing
- Reset values: `pwm_out=0`, `phase=0`, `duty_applied=0`, `period_start=0`, `pre_cnt=0`.
- Period is `8*PRESCALE` clk. Each slot lasts `PRESCALE` clk.
- `pwm_out` lags `phase`/`duty_applied` by exactly 1 clk, since it is registered from them.
- Latency from a `dc_control` change to its effect on `duty_applied`:
  - The change takes effect at the next wrap edge.
  - Worst case is `8*PRESCALE` clk for a decrease.
  - A rise of N codes needs N wraps.
- `dc_control` is sampled only at the wrap edge. It must be stable for that one edge; changes at other times are ignored.
- First `tick` after reset or enable occurs `PRESCALE` clk after `en` is sampled high.
- Simultaneous events:
  - `rst` together with the wrap: reset wins.
  - `en` falling on the wrap edge: the idle state wins, so no `period_start` and no duty update.

## Test plan
- Soft-start ramp (`PRESCALE=2`, `en=1`, `dc_control=7` after reset):
  - `duty_applied` steps 0→1→…→7 at consecutive wraps, 16 clk apart.
  - Once at 7, `pwm_out` is high 14 of every 16 clk.
- Immediate decrease:
  - At `duty_applied=7`, set `dc_control=2` mid-period.
  - `duty_applied` holds 7 until the wrap, then becomes 2 in one step.
  - `pwm_out` is then high for exactly 4 clk per 16-clk period.
- Zero duty: `dc_control=0` for 5 periods → `pwm_out` stays 0 and `duty_applied` stays 0.
- Enable drop:
  - Deassert `en` at `phase=3`, `duty_applied=5`. The next edge gives `phase=0`, `duty_applied=0`, `pwm_out=0`.
  - Reassert `en`: ramp restarts with the first `tick` 2 clk later.
- Mid-operation reset:
  - Assert `rst` for 1 clk while `en=1` and `pwm_out=1`.
  - All outputs read 0 at the next edge; operation resumes from slot 0.
- `period_start`/`phase` alignment (`PRESCALE=1`):
  - `period_start` pulses for exactly 1 clk every 8 clk, always with `phase=0`.
  - Never pulses while `en=0`.
